// File: rtl/divisor_8bits.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, start/ready handshake.
// Results are held in output registers until the next accepted operation completes.
module divisor_8bits #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quociente,
  output logic [N-1:0] resto,
  output logic         pronto,
  output logic         ocupado,
  output logic         div_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } state_t;

  state_t         state_r, state_nxt;
  logic [CW-1:0]  cnt_r, cnt_nxt;
  logic [N-1:0]   q_r, q_nxt;
  logic [N-1:0]   r_r, r_nxt;
  logic [N-1:0]   d_r, d_nxt;
  logic [N-1:0]   quo_nxt, res_nxt;
  logic           dz_nxt, pronto_nxt, ocupado_nxt;

  // Shifted partial remainder keeps the bit pushed out of R, hence N+1 bits.
  logic [N:0]     r_ext;
  logic [N+1:0]   trial;
  logic           no_borrow;

  // Trial subtraction r_ext - D as r_ext + ~D + 1; the carry out means no borrow.
  always_comb begin
    r_ext     = {r_r, q_r[N-1]};
    trial     = {1'b0, r_ext} + {1'b0, ~{1'b0, d_r}} + {{(N+1){1'b0}}, 1'b1};
    no_borrow = trial[N+1];
  end

  // Next-state and next-register values for the divider FSM.
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    q_nxt      = q_r;
    r_nxt      = r_r;
    d_nxt      = d_r;
    quo_nxt    = quociente;
    res_nxt    = resto;
    dz_nxt     = div_zero;
    pronto_nxt = 1'b0;
    case (state_r)
      OCIOSO: begin
        if (iniciar) begin
          if (divisor != {N{1'b0}}) begin
            q_nxt     = dividendo;
            r_nxt     = {N{1'b0}};
            d_nxt     = divisor;
            cnt_nxt   = {CW{1'b0}};
            dz_nxt    = 1'b0;
            state_nxt = CALCULA;
          end else begin
            quo_nxt    = {N{1'b1}};
            res_nxt    = dividendo;
            dz_nxt     = 1'b1;
            pronto_nxt = 1'b1;
            state_nxt  = FIM;
          end
        end else begin
          state_nxt = OCIOSO;
        end
      end
      CALCULA: begin
        q_nxt   = {q_r[N-2:0], no_borrow};
        r_nxt   = no_borrow ? trial[N-1:0] : r_ext[N-1:0];
        cnt_nxt = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_r == CW'(N-1)) begin
          quo_nxt    = q_nxt;
          res_nxt    = r_nxt;
          cnt_nxt    = {CW{1'b0}};
          pronto_nxt = 1'b1;
          state_nxt  = FIM;
        end else begin
          state_nxt = CALCULA;
        end
      end
      FIM: begin
        state_nxt = OCIOSO;
      end
      default: begin
        state_nxt = OCIOSO;
      end
    endcase
    ocupado_nxt = (state_nxt != OCIOSO);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= OCIOSO;
      cnt_r     <= {CW{1'b0}};
      q_r       <= {N{1'b0}};
      r_r       <= {N{1'b0}};
      d_r       <= {N{1'b0}};
      quociente <= {N{1'b0}};
      resto     <= {N{1'b0}};
      div_zero  <= 1'b0;
      pronto    <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      q_r       <= q_nxt;
      r_r       <= r_nxt;
      d_r       <= d_nxt;
      quociente <= quo_nxt;
      resto     <= res_nxt;
      div_zero  <= dz_nxt;
      pronto    <= pronto_nxt;
      ocupado   <= ocupado_nxt;
    end
  end

endmodule

// File: tb/tb_divisor_8bits.sv
// Scoreboard bench for divisor_8bits: drivers push expected results and pronto cycle,
// a negedge monitor pops and compares on every pronto pulse.
module tb_divisor_8bits;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         iniciar = 1'b0;
  logic [N-1:0] dividendo = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quociente, resto;
  logic         pronto, ocupado, div_zero;

  divisor_8bits #(.N(N)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .dividendo(dividendo), .divisor(divisor),
    .quociente(quociente), .resto(resto),
    .pronto(pronto), .ocupado(ocupado), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every pronto pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && pronto === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pronto", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {8'h00, quociente, resto, 7'd0, div_zero},
                        {8'h00, e.q, e.r, 7'd0, e.dz});
        check("pronto_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one start; pronto is expected N edges after acceptance, or on the same edge for /0.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz);
    @(negedge clock);
    iniciar = 1'b1; dividendo = a; divisor = b;
    @(posedge clock); #1;
    sb.push_back('{eq, er, edz, cyc + ((b == 8'd0) ? 0 : N)});
    check("ocupado_after_start", {31'd0, ocupado}, 32'd1);
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic wait_done();
    int i = 0;
    while (sb.size() != 0 && i < 40) begin
      @(posedge clock); #2;
      i++;
    end
    check("drain", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    logic [7:0] a, b, eq, er;
    logic       edz;
    int         p;

    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_outputs", {13'd0, quociente, resto, pronto, ocupado, div_zero}, 32'd0);

    start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);   wait_done();
    start_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);  wait_done();
    start_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);      wait_done();
    start_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);  wait_done();
    start_op(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);      wait_done();

    start_op(8'd200, 8'd0, 8'hFF, 8'd200, 1'b1); wait_done();
    start_op(8'd10, 8'd3, 8'd3, 8'd1, 1'b0);     wait_done();

    // A start pulse while busy must be ignored: only one pronto, for 100/7.
    start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (2) @(negedge clock);
    iniciar = 1'b1; dividendo = 8'd50; divisor = 8'd5;
    @(negedge clock);
    iniciar = 1'b0;
    check("results_held_busy", {16'd0, quociente, resto}, {16'd0, 8'd3, 8'd1});
    wait_done();
    start_op(8'd50, 8'd5, 8'd10, 8'd0, 1'b0);    wait_done();

    // Reset in the middle of 200/3: everything clears at once and no pronto follows.
    start_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midop_reset_outputs", {13'd0, quociente, resto, pronto, ocupado, div_zero}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    check("idle_after_reset", {30'd0, pronto, ocupado}, 32'd0);
    start_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0);   wait_done();

    // iniciar held high: a new operation is accepted as soon as the FSM is back in OCIOSO,
    // i.e. every N+2 edges (CALCULA x N, FIM, OCIOSO), or every 2 edges for divide-by-zero.
    @(negedge clock);
    a = 8'($urandom); b = 8'($urandom);
    iniciar = 1'b1; dividendo = a; divisor = b;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock); #1;
      if (b == 8'd0) begin eq = 8'hFF; er = a; edz = 1'b1; p = 2; end
      else begin eq = a / b; er = a % b; edz = 1'b0; p = N + 2; end
      sb.push_back('{eq, er, edz, cyc + ((b == 8'd0) ? 0 : N)});
      @(negedge clock);
      if (i == 999) begin
        iniciar = 1'b0;
      end else begin
        a = 8'($urandom); b = 8'($urandom);
        dividendo = a; divisor = b;
        repeat (p - 1) @(posedge clock);
      end
    end
    wait_done();
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
